// File: rtl/dac8531_spi_master.sv
// rtl/dac8531_spi_master.sv - SPI write engine for the DAC8531: one 24-bit {6'b0, PD_MODE, DATA} frame per TR rising edge.
// All outputs are registered from the next-state decode, so pins change only on CLK edges.
module dac8531_spi_master #(
    parameter int          CLK_DIV  = 2,
    parameter int          SYNC_GAP = 4,
    parameter logic [1:0]  PD_MODE  = 2'b00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TR,
    input  logic [15:0] DATA,
    output logic        DA_CS,
    output logic        DA_SCLK,
    output logic        DA_SDO,
    output logic        OVER
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'(SYNC_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [HW-1:0]  hcnt, hcnt_n;
    logic [GW-1:0]  gcnt, gcnt_n;
    logic [4:0]     bcnt, bcnt_n;
    logic           low, low_n;
    logic [23:0]    shreg, shreg_n;
    logic           tr_d;
    logic           start;
    logic           cs_n, sclk_n, sdo_n, over_n;

    assign start = TR & ~tr_d;

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        gcnt_n  = gcnt;
        bcnt_n  = bcnt;
        low_n   = low;
        shreg_n = shreg;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETUP;
                    shreg_n = {6'b0, PD_MODE, DATA};
                    hcnt_n  = '0;
                end
            end
            SETUP: begin
                if (hcnt == H_LAST) begin
                    state_n = SHIFT;
                    hcnt_n  = '0;
                    bcnt_n  = 5'd0;
                    low_n   = 1'b1;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            SHIFT: begin
                if (hcnt != H_LAST) begin
                    hcnt_n = hcnt + 1'b1;
                end else begin
                    hcnt_n = '0;
                    if (low) begin
                        // Next bit appears at the rising edge; after bit0 only zeros remain.
                        low_n   = 1'b0;
                        shreg_n = {shreg[22:0], 1'b0};
                    end else if (bcnt == 5'd23) begin
                        state_n = GAP;
                        gcnt_n  = '0;
                    end else begin
                        bcnt_n = bcnt + 5'd1;
                        low_n  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gcnt == G_LAST) begin
                    state_n = IDLE;
                end else begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        cs_n   = ~((state_n == SETUP) || (state_n == SHIFT));
        sclk_n = ~((state_n == SHIFT) && low_n);
        sdo_n  = ((state_n == SETUP) || (state_n == SHIFT)) ? shreg_n[23] : 1'b0;
        over_n = (state_n == IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            hcnt    <= '0;
            gcnt    <= '0;
            bcnt    <= 5'd0;
            low     <= 1'b0;
            shreg   <= 24'd0;
            tr_d    <= 1'b0;
            DA_CS   <= 1'b1;
            DA_SCLK <= 1'b1;
            DA_SDO  <= 1'b0;
            OVER    <= 1'b1;
        end else begin
            state   <= state_n;
            hcnt    <= hcnt_n;
            gcnt    <= gcnt_n;
            bcnt    <= bcnt_n;
            low     <= low_n;
            shreg   <= shreg_n;
            tr_d    <= TR;
            DA_CS   <= cs_n;
            DA_SCLK <= sclk_n;
            DA_SDO  <= sdo_n;
            OVER    <= over_n;
        end
    end

endmodule

// File: tb/tb_dac8531_spi_master.sv
// tb/tb_dac8531_spi_master.sv - directed/random bench for dac8531_spi_master with a falling-edge DAC receiver model.
module tb_dac8531_spi_master;

    logic        clk = 1'b0;
    logic        reset, tr, tr_b;
    logic [15:0] data, data_b;
    logic        cs_a, sclk_a, sdo_a, over_a;
    logic        cs_b, sclk_b, sdo_b, over_b;

    int checks = 0;
    int failures = 0;

    dac8531_spi_master #(.CLK_DIV(2), .SYNC_GAP(4), .PD_MODE(2'b00)) dut_a (
        .CLK(clk), .RESET(reset), .TR(tr), .DATA(data),
        .DA_CS(cs_a), .DA_SCLK(sclk_a), .DA_SDO(sdo_a), .OVER(over_a)
    );

    dac8531_spi_master #(.CLK_DIV(1), .SYNC_GAP(1), .PD_MODE(2'b11)) dut_b (
        .CLK(clk), .RESET(reset), .TR(tr_b), .DATA(data_b),
        .DA_CS(cs_b), .DA_SCLK(sclk_b), .DA_SDO(sdo_b), .OVER(over_b)
    );

    initial forever #5 clk = ~clk;

    // DAC receiver model per instance: shifts DIN in on each SCLK fall while SYNC is low.
    logic [1:0] m_cs, m_sclk, m_sdo, m_over;
    assign m_cs   = {cs_b, cs_a};
    assign m_sclk = {sclk_b, sclk_a};
    assign m_sdo  = {sdo_b, sdo_a};
    assign m_over = {over_b, over_a};

    int          div_of[2] = '{2, 1};
    int          gap_of[2] = '{4, 1};
    logic        mon_en = 1'b0;
    logic        pcs[2]   = '{1'b1, 1'b1};
    logic        psclk[2] = '{1'b1, 1'b1};
    logic        pover[2] = '{1'b1, 1'b1};
    int          edges[2] = '{0, 0};
    logic [23:0] shv[2];
    logic [23:0] fr_word[2][32];
    int          fr_edges[2][32];
    int          fr_n[2] = '{0, 0};
    int          ov_len[2][32];
    int          ov_n[2] = '{0, 0};
    int          ocnt[2] = '{0, 0};
    int          since_fall[2] = '{0, 0};
    int          bad_period[2] = '{0, 0};
    int          idle_edges[2] = '{0, 0};
    int          cs_run[2] = '{1000, 1000};
    int          short_gap[2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_en) begin
                since_fall[i]++;
                if (m_cs[i] && pcs[i] && (m_sclk[i] !== psclk[i])) idle_edges[i]++;
                if (!m_cs[i]) begin
                    if (pcs[i]) begin
                        edges[i] = 0;
                        if (cs_run[i] < gap_of[i]) short_gap[i]++;
                        cs_run[i] = 0;
                    end
                    if (psclk[i] && !m_sclk[i]) begin
                        if (edges[i] > 0 && since_fall[i] != 2 * div_of[i]) bad_period[i]++;
                        since_fall[i] = 0;
                        shv[i] = {shv[i][22:0], m_sdo[i]};
                        edges[i]++;
                    end
                end else begin
                    cs_run[i]++;
                    if (!pcs[i]) begin
                        fr_word[i][fr_n[i] % 32]  = shv[i];
                        fr_edges[i][fr_n[i] % 32] = edges[i];
                        fr_n[i]++;
                    end
                end
                if (!m_over[i]) ocnt[i]++;
                else if (!pover[i]) begin
                    ov_len[i][ov_n[i] % 32] = ocnt[i];
                    ov_n[i]++;
                    ocnt[i] = 0;
                end
            end
            pcs[i]   = m_cs[i];
            psclk[i] = m_sclk[i];
            pover[i] = m_over[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [15:0] d);
        data = d;
        tr = 1'b1;
        step(2);
        tr = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        while (over_a !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk("wait_over_a", {31'd0, over_a}, 32'd1);
    endtask

    function automatic logic [23:0] frame_of(input logic [1:0] pd, input logic [15:0] d);
        return {6'b0, pd, d};
    endfunction

    int          fb, ob;
    logic [15:0] w;
    logic [15:0] ws[3];

    initial begin
        reset = 1'b1; tr = 1'b1; tr_b = 1'b0; data = 16'h0; data_b = 16'h0;

        // Reset held with TR high
        step(1);
        mon_en = 1'b1;
        step(2);
        chk("reset_cs", {31'd0, cs_a}, 32'd1);
        chk("reset_sclk", {31'd0, sclk_a}, 32'd1);
        chk("reset_sdo", {31'd0, sdo_a}, 32'd0);
        chk("reset_over", {31'd0, over_a}, 32'd1);
        chk("reset_over_b", {31'd0, over_b}, 32'd1);
        reset = 1'b0; tr = 1'b0;
        step(2);
        chk("reset_no_frame", fr_n[0], 0);

        // Basic frame
        fb = fr_n[0]; ob = ov_n[0];
        pulse_a(16'd31200);
        chk("basic_over_low_after_pulse", {31'd0, over_a}, 32'd0);
        wait_idle_a(200);
        step(2);
        chk("basic_frame_count", fr_n[0] - fb, 1);
        chk("basic_word", fr_word[0][fb % 32], 32'h0079E0);
        chk("basic_edges", fr_edges[0][fb % 32], 24);
        chk("basic_over_len", ov_len[0][ob % 32], 102);

        // TR held high: exactly one frame
        fb = fr_n[0];
        w = 16'($urandom);
        data = w; tr = 1'b1;
        step(1);
        data = ~w;
        step(299);
        tr = 1'b0;
        step(2);
        chk("held_frame_count", fr_n[0] - fb, 1);
        chk("held_word", fr_word[0][fb % 32], frame_of(2'b00, w));

        // Retrigger while busy is dropped
        fb = fr_n[0];
        w = 16'($urandom);
        pulse_a(w);
        step(16);
        chk("retrig_busy", {31'd0, over_a}, 32'd0);
        data = 16'h1234; tr = 1'b1;
        step(2);
        tr = 1'b0;
        wait_idle_a(200);
        step(20);
        chk("retrig_frame_count", fr_n[0] - fb, 1);
        chk("retrig_word", fr_word[0][fb % 32], frame_of(2'b00, w));
        chk("retrig_edges", fr_edges[0][fb % 32], 24);

        // Abort mid-frame with RESET
        fb = fr_n[0];
        pulse_a(16'($urandom));
        step(38);
        reset = 1'b1;
        step(1);
        chk("abort_cs", {31'd0, cs_a}, 32'd1);
        chk("abort_over", {31'd0, over_a}, 32'd1);
        chk("abort_sclk", {31'd0, sclk_a}, 32'd1);
        reset = 1'b0;
        step(3);
        chk("abort_frame_seen", fr_n[0] - fb, 1);
        chk("abort_partial", {31'd0, fr_edges[0][fb % 32] < 24}, 32'd1);
        fb = fr_n[0]; ob = ov_n[0];
        pulse_a(16'hFFFF);
        wait_idle_a(200);
        step(3);
        chk("after_abort_count", fr_n[0] - fb, 1);
        chk("after_abort_word", fr_word[0][fb % 32], 32'h00FFFF);
        chk("after_abort_edges", fr_edges[0][fb % 32], 24);
        chk("after_abort_over_len", ov_len[0][ob % 32], 102);

        // Alternate parameters on instance b
        fb = fr_n[1]; ob = ov_n[1];
        data_b = 16'hA5A5; tr_b = 1'b1;
        step(2);
        tr_b = 1'b0;
        for (int n = 0; n < 200 && over_b !== 1'b1; n++) step(1);
        chk("b_wait_over", {31'd0, over_b}, 32'd1);
        step(3);
        chk("b_frame_count", fr_n[1] - fb, 1);
        chk("b_word", fr_word[1][fb % 32], 32'h03A5A5);
        chk("b_edges", fr_edges[1][fb % 32], 24);
        chk("b_over_len", ov_len[1][ob % 32], 50);
        chk("b_sclk_period", bad_period[1], 0);

        // Calibration-loop handshake, three random words back to back
        fb = fr_n[0]; ob = ov_n[0];
        for (int k = 0; k < 3; k++) begin
            wait_idle_a(200);
            ws[k] = 16'($urandom);
            pulse_a(ws[k]);
            wait_idle_a(200);
        end
        step(3);
        chk("loop_frame_count", fr_n[0] - fb, 3);
        for (int k = 0; k < 3; k++) begin
            chk("loop_word", fr_word[0][(fb + k) % 32], frame_of(2'b00, ws[k]));
            chk("loop_edges", fr_edges[0][(fb + k) % 32], 24);
            chk("loop_over_len", ov_len[0][(ob + k) % 32], 102);
        end

        chk("cs_gap_a", short_gap[0], 0);
        chk("sclk_period_a", bad_period[0], 0);
        chk("idle_sclk_edges_a", idle_edges[0], 0);
        chk("idle_sclk_edges_b", idle_edges[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
